lsu_mem_initiator: RTL and testbench
====================================

// Module: lsu_mem_initiator
// PURPOSE
//  Load/store initiator that drives the memory controller's valid/wen/raddr/waddr/wdata/wmask port.
//  Accepts one RV32 load/store from the execute stage and issues a word-aligned memory request.
//  Returns lane-extracted, sign- or zero-extended load data.
//  Sits between the EXU and the DPI-backed memory controller; one transaction in flight at a time.
// PARAMETERS
//  TIMEOUT_CYCLES  16  cycles waited in WAIT for mem_ack before reporting an error response.
// PORTS
//  clk           in   1   single clock; all state updates on posedge.
//  rst           in   1   asynchronous, active-high reset.
//  req_valid     in   1   EXU presents a request.
//  req_ready     out  1   initiator can accept a request (high only in IDLE).
//  req_wen       in   1   1 = store, 0 = load.
//  req_addr      in   32  byte address.
//  req_wdata     in   32  store data, right-justified.
//  req_size      in   2   0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
//  req_unsigned  in   1   load zero-extends (LBU/LHU) when 1.
//  rsp_valid     out  1   one-cycle pulse: transaction complete.
//  rsp_rdata     out  32  extended load data; 0 for stores and errors.
//  rsp_err       out  1   qualifies rsp_valid: timeout, or misaligned access when checking is enabled.
//  mem_valid     out  1   request to memory controller.
//  mem_wen       out  1   write enable.
//  mem_raddr     out  32  {addr[31:2],2'b00} on loads, 0 on stores.
//  mem_waddr     out  32  {addr[31:2],2'b00} on stores, 0 on loads.
//  mem_wdata     out  32  store data shifted to byte lane.
//  mem_wmask     out  8   byte mask; bits [7:4] always 0.
//  mem_rdata     in   32  read word from memory controller.
//  mem_ack       in   1   memory has completed the access; tie to 1 for a combinational controller.
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; every other output = 0; timeout counter = 0.
//  Reset mid-transaction aborts it silently: no rsp_valid is produced and mem_valid drops asynchronously.
//  FSM: IDLE -> REQ on req_valid&&req_ready. The request is registered at this edge.
//   REQ:  mem_* outputs driven from registers; mem_valid=1.
//         mem_ack=1 -> DONE (mem_rdata captured at this edge). mem_ack=0 -> WAIT.
//   WAIT: mem_valid stays 1 and all mem_* outputs stay stable.
//         mem_ack=1 -> DONE (rdata captured). Counter reaches TIMEOUT_CYCLES-1 -> DONE with err=1.
//   DONE: rsp_valid=1 for exactly one cycle; mem_valid=0 -> IDLE.
//  Latency with mem_ack tied to 1: request accepted at edge N, mem_valid high in cycle N+1,
//   rsp_valid high in cycle N+2, req_ready high again in cycle N+3.
//  Requests arriving in REQ/WAIT/DONE are not accepted; req_ready=0 in those states.
//  The store lane offset is o = addr[1:0].
//   Store mask: byte = 4'b0001<<o; half = 4'b0011<<o; word = 4'b1111.
//   The mask is truncated to 4 bits, so bytes that cross the word boundary are dropped.
//   Store data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata. The lane is selected by the mask.
//  Load extract:
//   byte = mem_rdata[8*o +: 8]; half = mem_rdata[8*o +: 16], with the upper byte 0 if o=3; word as-is.
//   Sign-extend from bit 7/15 unless req_unsigned is set.
//  Timeout: the counter clears on entering REQ and increments each WAIT cycle.
//   A timeout gives rsp_err=1 and rsp_rdata=0. A late mem_ack arriving after DONE is ignored.
// CONFIGURATION
//  LSU_MISALIGN_CHECK_EN defined: a misaligned half (addr[0]) or word (addr[1:0]!=0) request goes IDLE -> DONE.
//   No memory access occurs (mem_valid never rises). The response is rsp_err=1, rsp_rdata=0.
//  LSU_MISALIGN_CHECK_EN undefined: no check; lanes and masks follow the truncation rules above.
// STRUCTURE
//  Package lsu_pkg:
//   lsu_size_e (SZ_B/SZ_H/SZ_W), lsu_state_e (IDLE/REQ/WAIT/DONE), WORD_W=32, MASK_W=8.
//  Sub-module lsu_lane_align: combinational store shift and mask generation, and load extract/extend.
//   It is instanced once. The FSM, registers and timeout counter stay in lsu_mem_initiator.
// TESTING
//  SW addr=0x80000004 wdata=0xDEADBEEF, ack=1 -> waddr=0x80000004 wmask=0x0F wdata=0xDEADBEEF; rsp_valid at N+2, err=0.
//  SB addr=0x80000003 wdata=0x000000A5 -> waddr=0x80000000 wmask=0x08 wdata=0xA5A5A5A5.
//  LB addr=..2 with mem_rdata=0x12F34567 -> rdata=0xFFFFFFF3; LBU at the same address -> rdata=0x000000F3.
//  LH addr=..2 with mem_rdata=0x80017777 -> rdata=0xFFFF8001.
//   With ack held low 3 cycles: mem_valid stays 1 for 4 cycles with stable address, then rsp_valid.
//  ack never asserted with TIMEOUT_CYCLES=16 -> rsp_valid with err=1, rdata=0; req_ready=0 throughout.
//  LW addr=..1: with LSU_MISALIGN_CHECK_EN, mem_valid stays 0 and rsp err=1 in cycle N+1.
//   Without the macro, the access proceeds. Assert rst during WAIT -> all outputs 0, no rsp_valid.

Source files
------------

// File: rtl/lsu_mem_initiator_pkg.sv
// Shared types for the LSU memory initiator: access sizes, FSM states,
// bus widths and small decode helpers.
package lsu_pkg;
  localparam int WORD_W = 32;
  localparam int MASK_W = 8;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} lsu_size_e;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

  // Encoding 3 is illegal on the EXU side; fold it onto word.
  function automatic lsu_size_e decode_size(input logic [1:0] s);
    case (s)
      2'd0:    return SZ_B;
      2'd1:    return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/lsu_mem_initiator_if.sv
// EXU request/response and memory-controller port bundle.
// master = the initiator itself, slave = the surrounding EXU/memory.
interface lsu_mem_initiator_if;
  import lsu_pkg::*;
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_valid;
  logic              mem_wen;
  logic [WORD_W-1:0] mem_raddr;
  logic [WORD_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
    input  mem_rdata, mem_ack
  );
  modport slave (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu_mem_initiator_lane_align.sv
// Byte-lane steering: store data replication + mask, load extract + extend.
// Pure combinational; store side works on the incoming request, load side
// on the request registered at accept time.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]        st_off,
  input  lsu_size_e         st_size,
  input  logic [WORD_W-1:0] st_data,
  output logic [WORD_W-1:0] st_wdata,
  output logic [MASK_W-1:0] st_wmask,
  input  logic [1:0]        ld_off,
  input  lsu_size_e         ld_size,
  input  logic              ld_unsigned,
  input  logic [WORD_W-1:0] ld_word,
  output logic [WORD_W-1:0] ld_data
);
  logic [3:0]        m4;
  logic [WORD_W-1:0] shifted;

  // Store: replicate data across lanes; mask shift is truncated to 4 bits so
  // bytes past the word boundary are dropped.
  always_comb begin
    m4       = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      SZ_B: begin m4 = 4'b0001 << st_off; st_wdata = {4{st_data[7:0]}};  end
      SZ_H: begin m4 = 4'b0011 << st_off; st_wdata = {2{st_data[15:0]}}; end
      default: ;
    endcase
    st_wmask = {4'b0000, m4};
  end

  // Load: shift the addressed lane down; a half at offset 3 sees zero in its
  // upper byte because the shift fills with zeros.
  always_comb begin
    shifted = ld_word >> {ld_off, 3'b000};
    case (ld_size)
      SZ_B:    ld_data = {{24{~ld_unsigned & shifted[7]}},  shifted[7:0]};
      SZ_H:    ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
      default: ld_data = ld_word;
    endcase
  end
endmodule

// File: rtl/lsu_mem_initiator.sv
// RV32 load/store initiator: one transaction in flight, word-aligned memory
// request, timeout-protected wait for mem_ack, one-cycle response pulse.
// Optional LSU_MISALIGN_CHECK_EN: misaligned half/word requests are answered
// with an error directly from IDLE without touching memory.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                 clk,
  input logic                 rst,
  lsu_mem_initiator_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        r_off;
  lsu_size_e         r_size;
  logic              r_uns;
  logic              ready, rsp_vld, rsp_err, mem_vld, mem_wen;
  logic [WORD_W-1:0] rsp_rdata, mem_raddr, mem_waddr, mem_wdata;
  logic [MASK_W-1:0] mem_wmask;

  lsu_size_e         in_size;
  logic              bad;
  logic [WORD_W-1:0] st_wdata, ld_data, aligned;
  logic [MASK_W-1:0] st_wmask;

  assign in_size = decode_size(bus.req_size);
  assign aligned = {bus.req_addr[WORD_W-1:2], 2'b00};
`ifdef LSU_MISALIGN_CHECK_EN
  assign bad = is_misaligned(in_size, bus.req_addr[1:0]);
`else
  assign bad = 1'b0;
`endif

  lsu_lane_align u_align (
    .st_off     (bus.req_addr[1:0]),
    .st_size    (in_size),
    .st_data    (bus.req_wdata),
    .st_wdata   (st_wdata),
    .st_wmask   (st_wmask),
    .ld_off     (r_off),
    .ld_size    (r_size),
    .ld_unsigned(r_uns),
    .ld_word    (bus.mem_rdata),
    .ld_data    (ld_data)
  );

  // Transaction FSM; every bus output is a flop so reset clears them at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      r_off     <= 2'b00;
      r_size    <= SZ_B;
      r_uns     <= 1'b0;
      ready     <= 1'b1;
      rsp_vld   <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_vld   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      rsp_vld   <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: if (bus.req_valid && ready) begin
          ready  <= 1'b0;
          r_off  <= bus.req_addr[1:0];
          r_size <= in_size;
          r_uns  <= bus.req_unsigned;
          if (bad) begin
            state   <= DONE;
            rsp_vld <= 1'b1;
            rsp_err <= 1'b1;
          end else begin
            state     <= REQ;
            cnt       <= '0;
            mem_vld   <= 1'b1;
            mem_wen   <= bus.req_wen;
            mem_raddr <= bus.req_wen ? '0 : aligned;
            mem_waddr <= bus.req_wen ? aligned : '0;
            mem_wdata <= bus.req_wen ? st_wdata : '0;
            mem_wmask <= bus.req_wen ? st_wmask : '0;
          end
        end
        REQ, WAIT: begin
          if (bus.mem_ack || (state == WAIT && cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            state     <= DONE;
            rsp_vld   <= 1'b1;
            rsp_err   <= ~bus.mem_ack;
            rsp_rdata <= (bus.mem_ack && !mem_wen) ? ld_data : '0;
            mem_vld   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_raddr <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
          end else begin
            if (state == WAIT) cnt <= cnt + 1'b1;
            state <= WAIT;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_err   = rsp_err;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.mem_valid = mem_vld;
  assign bus.mem_wen   = mem_wen;
  assign bus.mem_raddr = mem_raddr;
  assign bus.mem_waddr = mem_waddr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_wmask = mem_wmask;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator (default TIMEOUT_CYCLES=16).
module tb_lsu_mem_initiator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  lsu_mem_initiator_if bus();

  lsu_mem_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge; it is accepted at the following posedge (edge N).
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_wen      = wen;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  initial begin
    int  mv;
    bit  seen;
    bit  rdy_bad;
    bus.req_valid    = 1'b0;
    bus.req_wen      = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.mem_rdata    = '0;
    bus.mem_ack      = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", bus.req_ready, 1);
    check("rst_mem_valid", bus.mem_valid, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_wmask", bus.mem_wmask, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    rst = 1'b0;

    // SW, ack tied high: latency N+1 / N+2 / N+3
    issue(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 1'b0);
    @(negedge clk);
    check("sw_mem_valid", bus.mem_valid, 1);
    check("sw_wen", bus.mem_wen, 1);
    check("sw_waddr", bus.mem_waddr, 32'h8000_0004);
    check("sw_raddr", bus.mem_raddr, 0);
    check("sw_wmask", bus.mem_wmask, 32'h0F);
    check("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("sw_ready_busy", bus.req_ready, 0);
    check("sw_rsp_early", bus.rsp_valid, 0);
    @(negedge clk);
    check("sw_rsp_valid", bus.rsp_valid, 1);
    check("sw_rsp_err", bus.rsp_err, 0);
    check("sw_rsp_rdata", bus.rsp_rdata, 0);
    check("sw_mem_drop", bus.mem_valid, 0);
    @(negedge clk);
    check("sw_ready_back", bus.req_ready, 1);
    check("sw_rsp_pulse", bus.rsp_valid, 0);

    // SB at offset 3
    issue(1'b1, 32'h8000_0003, 32'h0000_00A5, 2'd0, 1'b0);
    @(negedge clk);
    check("sb_waddr", bus.mem_waddr, 32'h8000_0000);
    check("sb_wmask", bus.mem_wmask, 32'h08);
    check("sb_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    repeat (2) @(negedge clk);

    // LB / LBU lane 2
    bus.mem_rdata = 32'h12F3_4567;
    issue(1'b0, 32'h8000_0002, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    check("lb_raddr", bus.mem_raddr, 32'h8000_0000);
    check("lb_waddr", bus.mem_waddr, 0);
    check("lb_wen", bus.mem_wen, 0);
    @(negedge clk);
    check("lb_rdata", bus.rsp_rdata, 32'hFFFF_FFF3);
    @(negedge clk);
    issue(1'b0, 32'h8000_0002, 32'h0, 2'd0, 1'b1);
    repeat (2) @(negedge clk);
    check("lbu_rdata", bus.rsp_rdata, 32'h0000_00F3);
    @(negedge clk);

    // LH lane 2 with ack low for 3 cycles
    bus.mem_rdata = 32'h8001_7777;
    bus.mem_ack   = 1'b0;
    issue(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 4) bus.mem_ack = 1'b1;
      check($sformatf("lh_wait_valid%0d", i), bus.mem_valid, 1);
      check($sformatf("lh_wait_raddr%0d", i), bus.mem_raddr, 32'h8000_0000);
      check($sformatf("lh_wait_rsp%0d", i), bus.rsp_valid, 0);
    end
    @(negedge clk);
    check("lh_rsp_valid", bus.rsp_valid, 1);
    check("lh_rdata", bus.rsp_rdata, 32'hFFFF_8001);
    check("lh_err", bus.rsp_err, 0);
    @(negedge clk);

    // Timeout: REQ + 16 WAIT cycles, then error response
    bus.mem_ack = 1'b0;
    issue(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0);
    mv = 0; seen = 0; rdy_bad = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
      else begin
        if (bus.mem_valid) mv++;
        if (bus.req_ready) rdy_bad = 1;
      end
    end
    check("to_seen", seen, 1);
    check("to_mem_cycles", mv, 17);
    check("to_ready_low", rdy_bad, 0);
    check("to_err", bus.rsp_err, 1);
    check("to_rdata", bus.rsp_rdata, 0);
    check("to_ready_done", bus.req_ready, 0);
    @(negedge clk);
    bus.mem_ack = 1'b1;   // late ack in IDLE is ignored
    @(negedge clk);
    check("late_ack_rsp", bus.rsp_valid, 0);
    check("late_ack_mem", bus.mem_valid, 0);
    check("late_ack_ready", bus.req_ready, 1);

    // Misaligned LW at offset 1
    bus.mem_rdata = 32'h1122_3344;
    issue(1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0);
    @(negedge clk);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_mem_valid", bus.mem_valid, 0);
    check("mis_rsp_valid", bus.rsp_valid, 1);
    check("mis_err", bus.rsp_err, 1);
    check("mis_rdata", bus.rsp_rdata, 0);
    @(negedge clk);
`else
    check("mis_mem_valid", bus.mem_valid, 1);
    check("mis_raddr", bus.mem_raddr, 32'h8000_0000);
    @(negedge clk);
    check("mis_rsp_valid", bus.rsp_valid, 1);
    check("mis_err", bus.rsp_err, 0);
    check("mis_rdata", bus.rsp_rdata, 32'h1122_3344);
    @(negedge clk);
    // Half at offset 3: mask truncated, upper byte of loaded half is 0
    issue(1'b1, 32'h8000_0003, 32'h0000_BEEF, 2'd1, 1'b0);
    @(negedge clk);
    check("sh3_wmask", bus.mem_wmask, 32'h08);
    check("sh3_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
    repeat (2) @(negedge clk);
    bus.mem_rdata = 32'hF000_0000;
    issue(1'b0, 32'h8000_0003, 32'h0, 2'd1, 1'b0);
    repeat (2) @(negedge clk);
    check("lh3_rdata", bus.rsp_rdata, 32'h0000_00F0);
    @(negedge clk);
`endif

    // Reset asserted during WAIT aborts silently
    bus.mem_ack = 1'b0;
    issue(1'b0, 32'h8000_0020, 32'h0, 2'd2, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_in_wait", bus.mem_valid, 1);
    rst = 1'b1;
    #1;
    check("abort_mem_valid", bus.mem_valid, 0);
    check("abort_raddr", bus.mem_raddr, 0);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_ready", bus.req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    check("abort_no_rsp", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
